psub16_pipe: RTL and testbench



---
 rtl/psub16_pipe.sv | 136 +++++++++++++
 tb/tb_psub16_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/psub16_pipe.sv
// psub16_pipe: two-stage pipelined 16-bit subtractor with borrow-in/out and
// valid/ready handshakes. The borrow chain is split at the byte boundary.
// Optional zero/overflow flags are enabled by defining PSUB16_FLAGS_EN.
module psub16_pipe #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         Z,
  output logic         V
);

  localparam int unsigned HW  = N / 2;
  localparam int unsigned HW1 = HW + 1;

  // Stage 1 registers: low byte result, byte borrow, upper operand bytes
  logic          s1_valid_q, s1_valid_d;
  logic [HW-1:0] s1_dlo_q,   s1_dlo_d;
  logic          s1_b8_q,    s1_b8_d;
  logic [HW-1:0] s1_ahi_q,   s1_ahi_d;
  logic [HW-1:0] s1_bhi_q,   s1_bhi_d;

  // Output register
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  d_q,         d_d;
  logic          bout_q,      bout_d;

  logic          s1_take_c;
  logic          s2_take_c;
  logic [HW:0]   lo_diff_c;
  logic [HW:0]   hi_diff_c;

  // Handshake advance conditions; in_ready never depends on in_valid
  assign s2_take_c = !out_valid_q || out_ready;
  assign s1_take_c = !s1_valid_q || s2_take_c;
  assign in_ready  = s1_take_c;

  // Byte-wide subtracts; the extra MSB is the borrow out of each byte
  assign lo_diff_c = {1'b0, A[HW-1:0]} - {1'b0, B[HW-1:0]} - HW1'(Bin);
  assign hi_diff_c = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q} - HW1'(s1_b8_q);

  // Next-state for both stages; held stages keep their contents
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dlo_d    = s1_dlo_q;
    s1_b8_d     = s1_b8_q;
    s1_ahi_d    = s1_ahi_q;
    s1_bhi_d    = s1_bhi_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    bout_d      = bout_q;
    if (s1_take_c) begin
      s1_valid_d = in_valid;
      s1_dlo_d   = lo_diff_c[HW-1:0];
      s1_b8_d    = lo_diff_c[HW];
      s1_ahi_d   = A[N-1:HW];
      s1_bhi_d   = B[N-1:HW];
    end
    if (s2_take_c) begin
      out_valid_d = s1_valid_q;
      d_d         = {hi_diff_c[HW-1:0], s1_dlo_q};
      bout_d      = hi_diff_c[HW];
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dlo_q    <= '0;
      s1_b8_q     <= 1'b0;
      s1_ahi_q    <= '0;
      s1_bhi_q    <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dlo_q    <= s1_dlo_d;
      s1_b8_q     <= s1_b8_d;
      s1_ahi_q    <= s1_ahi_d;
      s1_bhi_q    <= s1_bhi_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;

`ifdef PSUB16_FLAGS_EN
  // Flags are computed from the S1 operand sign bits of the same transaction
  logic z_q, z_d;
  logic v_q, v_d;

  // Flag next-state, loaded together with the output register
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    if (s2_take_c) begin
      z_d = (hi_diff_c[HW-1:0] == '0) && (s1_dlo_q == '0);
      v_d = (s1_ahi_q[HW-1] != s1_bhi_q[HW-1]) &&
            (hi_diff_c[HW-1] != s1_ahi_q[HW-1]);
    end
  end

  // Flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      v_q <= v_d;
    end
  end

  assign Z = z_q;
  assign V = v_q;
`else
  assign Z = 1'b0;
  assign V = 1'b0;
`endif

endmodule

// File: tb/tb_psub16_pipe.sv
// Self-checking bench for psub16_pipe: directed vector table, backpressure
// and mid-flight reset sequences, and randomized traffic against a queue
// based transaction model.
module tb_psub16_pipe;

`ifdef PSUB16_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        Bout, Z, V;

  psub16_pipe #(.N(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .Z(Z), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        z;
    logic        v;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        z;
    logic        v;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   saw_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from plain wide arithmetic
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int unsigned diff;
    diff   = 32'(a) + 32'h10000 - 32'(b) - 32'(bin);
    e.d    = diff[15:0];
    e.bout = (32'(a) < 32'(b) + 32'(bin));
    e.z    = FLAGS && (e.d == 16'h0000);
    e.v    = FLAGS && (a[15] != b[15]) && (e.d[15] != a[15]);
    e.cyc  = cyc;
    return e;
  endfunction

  // One clock: observe at negedge, update the model, advance past posedge
  task automatic cycle(output bit acc);
    bit exp_ir, exp_ov;
    @(negedge clk);
    exp_ir = (q.size() < 2) || out_ready;
    exp_ov = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (!in_ready) saw_stall = 1'b1;
    if (exp_ov) begin
      chk("D", 32'(D), 32'(q[0].d));
      chk("Bout", 32'(Bout), 32'(q[0].bout));
      chk("Z", 32'(Z), 32'(q[0].z));
      chk("V", 32'(V), 32'(q[0].v));
      if (out_ready) void'(q.pop_front());
    end
    acc = in_valid && exp_ir;
    if (acc) q.push_back(model(A, B, Bin));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    bit acc;
    int k, t;
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0100, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, result visible after two edges
    foreach (vecs[i]) begin
      in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; Bin = vecs[i].bin;
      cycle(acc);
      chk("vec_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      cycle(acc);
      chk("vec_ov", 32'(out_valid), 32'd1);
      chk("vec_D", 32'(D), 32'(vecs[i].d));
      chk("vec_Bout", 32'(Bout), 32'(vecs[i].bout));
      chk("vec_Z", 32'(Z), 32'(FLAGS & vecs[i].z));
      chk("vec_V", 32'(V), 32'(FLAGS & vecs[i].v));
      cycle(acc);
    end
    drain();

    // Backpressure: stream 5-k with out_ready low for cycles 2..5
    saw_stall = 1'b0;
    k = 0; t = 0;
    while (k < 6 && t < 40) begin
      in_valid  = 1'b1; A = 16'd5; B = 16'(k); Bin = 1'b0;
      out_ready = !(t >= 2 && t <= 5);
      cycle(acc);
      if (acc) k++;
      t++;
    end
    chk("bp_all_accepted", 32'(k), 32'd6);
    chk("bp_saw_stall", 32'(saw_stall), 32'd1);
    drain();

    // Asynchronous reset with two transfers in flight
    out_ready = 1'b1;
    in_valid = 1'b1; A = 16'h0042; B = 16'h0001; Bin = 1'b0;
    cycle(acc);
    A = 16'h0010;
    cycle(acc);
    in_valid = 1'b0;
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_D", 32'(D), 32'd0);
    chk("arst_Bout", 32'(Bout), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cycle(acc);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A   = 16'($urandom);
      B   = 16'($urandom);
      Bin = 1'($urandom);
      if ($urandom_range(0, 9) == 0) B = A;
      cycle(acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
